// File: rtl/debug_uart_dump_if.sv
// debug_uart_dump_if: dump trigger, SD/FAT32 debug bus and UART status.
interface debug_uart_dump_if;
   logic        trigger;
   logic [3:0]  sd_error;
   logic [4:0]  fat_state;
   logic [3:0]  fat_error;
   logic        sd_ready, fat_ready, image_loaded;
   logic [7:0]  dbg_byte0, dbg_byte1, dbg_byte510, dbg_byte511;
   logic [9:0]  dbg_blk_wr_idx, dbg_dir_idx;
   logic [31:0] dbg_part_lba, dbg_data_start, dbg_root_cluster, dbg_dir_lba;
   logic        uart_tx, busy, done;
   modport master (
      output trigger, sd_error, fat_state, fat_error, sd_ready, fat_ready, image_loaded,
             dbg_byte0, dbg_byte1, dbg_byte510, dbg_byte511, dbg_blk_wr_idx, dbg_dir_idx,
             dbg_part_lba, dbg_data_start, dbg_root_cluster, dbg_dir_lba,
      input  uart_tx, busy, done
   );
   modport slave (
      input  trigger, sd_error, fat_state, fat_error, sd_ready, fat_ready, image_loaded,
             dbg_byte0, dbg_byte1, dbg_byte510, dbg_byte511, dbg_blk_wr_idx, dbg_dir_idx,
             dbg_part_lba, dbg_data_start, dbg_root_cluster, dbg_dir_lba,
      output uart_tx, busy, done
   );
endinterface

// File: rtl/debug_uart_dump.sv
// debug_uart_dump: snapshots the SD/FAT32 debug bus on trigger and sends it
// as one 66-character ASCII hex line over an 8N1 UART.
module debug_uart_dump #(
   parameter int CLK_HZ = 74_250_000,
   parameter int BAUD   = 115_200
) (
   input  logic             clk,
   input  logic             rst_n,
   debug_uart_dump_if.slave bus
);
   localparam int DIV   = CLK_HZ / BAUD;
   localparam int CW    = $clog2(DIV);
   localparam int NCH   = 66;
   localparam int ND    = 51;
   localparam int SPACE = 51;
   localparam int CR    = 52;
   localparam int LF    = 53;
   localparam int FW [14] = '{1, 2, 1, 1, 2, 2, 2, 2, 3, 3, 8, 8, 8, 8};

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [6:0]      idx_q, idx_d;
   logic [ND*4-1:0] snap_q, snap_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic [ND*4-1:0] live;
   logic            accept, tick, load;
   logic [5:0]      kind, dsel;
   logic [3:0]      nib;
   logic [7:0]      chr;

   // Nibbles in transmit order, most significant first.
   assign live = {bus.sd_error, 3'b0, bus.fat_state, bus.fat_error,
                  1'b0, bus.image_loaded, bus.fat_ready, bus.sd_ready,
                  bus.dbg_byte0, bus.dbg_byte1, bus.dbg_byte510, bus.dbg_byte511,
                  2'b0, bus.dbg_blk_wr_idx, 2'b0, bus.dbg_dir_idx,
                  bus.dbg_part_lba, bus.dbg_data_start, bus.dbg_root_cluster, bus.dbg_dir_lba};

   // Character index -> digit number (0..50), SPACE, CR or LF.
   function automatic logic [5:0] char_kind(logic [6:0] n);
      int pos, dig;
      logic [5:0] k;
      pos = 0;
      dig = 0;
      k = 6'(LF);
      for (int f = 0; f < 14; f++) begin
         if (int'(n) >= pos && int'(n) < pos + FW[f]) k = 6'(dig + int'(n) - pos);
         pos += FW[f];
         dig += FW[f];
         if (int'(n) == pos) k = 6'(f == 13 ? CR : SPACE);
         pos += 1;
      end
      return k;
   endfunction

   always_comb begin
      accept  = state_q == IDLE && bus.trigger;
      tick    = cnt_q == CW'(DIV - 1);
      state_d = state_q;
      cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      idx_d   = idx_q;
      snap_d  = accept ? live : snap_q;
      done_d  = 1'b0;
      load    = 1'b0;
      case (state_q)
         IDLE: if (bus.trigger) begin
            state_d = START;
            idx_d   = '0;
            load    = 1'b1;
         end
         START: if (tick) begin
            state_d = DATA;
            bit_d   = '0;
         end
         DATA: if (tick) begin
            bit_d   = bit_q + 3'd1;
            state_d = (bit_q == 3'd7) ? STOP : DATA;
         end
         STOP: if (tick) begin
            if (idx_q == 7'(NCH - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = START;
               idx_d   = idx_q + 7'd1;
               load    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Next character resolved from the (possibly just-captured) snapshot.
      kind    = char_kind(idx_d);
      dsel    = (kind < 6'(ND)) ? kind : 6'd0;
      nib     = snap_d[4*(ND-1-int'(dsel)) +: 4];
      chr     = (kind == 6'(SPACE)) ? 8'h20 :
                (kind == 6'(CR))    ? 8'h0D :
                (kind == 6'(LF))    ? 8'h0A :
                (nib < 4'd10)       ? {4'h3, nib} : 8'h37 + {4'h0, nib};
      shift_d = load ? chr : shift_q;
      tx_d    = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[bit_d] : 1'b1;
      busy_d  = state_d != IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         snap_q  <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.uart_tx = tx_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
endmodule

// File: doc/debug_uart_dump.md
# debug_uart_dump

Serial counterpart to the on-screen boot/debug display. On a trigger it snapshots the SD/FAT32 debug bus into a holding register. It then transmits the snapshot as one ASCII hex line over an 8N1 UART. This gives a host terminal the same diagnostics the boot screen draws as hex glyphs. It sits beside the video path, fed by the same FAT32/SD debug signals, and drives a board UART TX pin.

## Interface
- CLK_HZ, 74_250_000, clk frequency in Hz
- BAUD, 115_200, serial bit rate; DIV = CLK_HZ / BAUD (integer floor), must be ≥ 2
- clk  in  1  system/pixel clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- trigger  in  1  start-dump request, sampled each clk
- sd_error  in  4  SD error code
- fat_state  in  5  FAT32 FSM state
- fat_error  in  4  FAT32 error code
- sd_ready, fat_ready, image_loaded  in  1 each  status flags
- dbg_byte0, dbg_byte1, dbg_byte510, dbg_byte511  in  8 each  sector buffer bytes
- dbg_blk_wr_idx, dbg_dir_idx  in  10 each  buffer write index / dir entry index
- dbg_part_lba, dbg_data_start, dbg_root_cluster, dbg_dir_lba  in  32 each  FAT32 parameters
- uart_tx  out  1  serial line, idle high
- busy  out  1  high while a dump is in progress
- done  out  1  one-cycle pulse when the final stop bit completes

## Operation
- Reset values: uart_tx=1, busy=0, done=0, FSM=IDLE. All snapshot and counter registers are 0.
- Accept: trigger=1 while busy=0.
  - In the same edge, all debug inputs are captured into the snapshot.
  - Later input changes have no effect on the line being sent.
  - trigger while busy=1 is ignored; no queuing.
- Line format is 66 characters, sent in this order, single space (0x20) between fields:
  - sd_error: 1 digit
  - {3'b0,fat_state}: 2 digits
  - fat_error: 1 digit
  - {1'b0,image_loaded,fat_ready,sd_ready}: 1 digit
  - byte0, byte1, byte510, byte511: 2 digits each
  - {2'b0,blk_wr_idx}: 3 digits
  - {2'b0,dir_idx}: 3 digits
  - part_lba, data_start, root_cluster, dir_lba: 8 digits each
  - then CR (0x0D) and LF (0x0A)
  - Totals: 51 hex digits, 13 spaces, CR, LF.
- Digits are sent most-significant nibble first. Encoding: 0–9 → 0x30–0x39, A–F → 0x41–0x46 (uppercase only).
- Character framing: start bit (0), 8 data bits LSB first, stop bit (1).
  - Characters are back-to-back with no idle gap between them.
- FSM states:
  - IDLE → START on accept.
  - START → DATA after DIV cycles.
  - DATA → STOP after 8×DIV cycles.
  - STOP → START (next char) or → IDLE (after char 65), each after DIV cycles.
- Character index runs 0..65. The character for index n+1 is resolved before its START begins.

## Timing
- Accept at edge t: busy=1 and uart_tx=0 (start bit) from t+1.
- Every bit lasts exactly DIV clk cycles. One character is 10×DIV cycles; the full dump is 660×DIV cycles.
  - At defaults, DIV=644: 425,040 cycles.
- Last stop bit ends at t+1+660×DIV. On that edge: busy→0, done=1 for exactly one cycle, uart_tx stays 1.
- trigger high on the cycle done is high is accepted (busy already 0). The next start bit begins the following cycle.
- Baud counter is 0..DIV-1 and wraps to 0 at each bit boundary. No fractional-rate accumulation.
- Mid-dump reset: uart_tx=1, busy=0, done=0 immediately (asynchronous). No partial character resumes after release.

## Test plan
- Reset and idle: hold rst_n=0, then release with trigger=0 for 1000 cycles → uart_tx=1, busy=0, done=0 throughout.
- Golden line (CLK_HZ=1_000_000, BAUD=100_000, so DIV=10):
  - Inputs: sd_error=0, fat_state=0x0B, fat_error=0, all three flags=1, bytes 49/0F/55/AA, blk_wr_idx=0x200, dir_idx=0x003, part_lba=0x00002000, data_start=0x00004000, root_cluster=0x00000002, dir_lba=0x00004000.
  - Pulse trigger; the bench UART decoder must receive exactly "0 0B 0 7 49 0F 55 AA 200 003 00002000 00004000 00000002 00004000" followed by 0x0D 0x0A.
- Bit timing (DIV=10): the start-bit falling edge is 1 cycle after accept, every bit is 10 cycles, and done pulses at accept+6601 with busy low the same cycle.
- Snapshot isolation: change all debug inputs to 0xFF…, and pulse trigger again, one cycle after accept → transmitted line is unchanged from the golden line, and no second dump starts.
- Retrigger on done: trigger held high continuously → consecutive dumps separated by exactly one idle-high cycle, each line identical.
- Reset mid-dump: assert rst_n=0 during a DATA bit of character 20 → uart_tx=1 and busy=0 asynchronously. After release, the line stays idle until the next trigger.
